// File: rtl/cordic_vectoring_iter.sv
// cordic_vectoring_iter: iterative vectoring CORDIC, unsigned (x, y) -> (atan2 in degrees, magnitude), one micro-rotation per clock.
// Define VECTOR_GAIN_COMP_EN to add the SCALE state that removes the CORDIC gain from the magnitude.
module cordic_vectoring_iter #(
    parameter int UNSIGNED_INPUT_WIDTH      = 16,
    parameter int UNSIGNED_OUTPUT_WIDTH     = 16,
    parameter int ITERATION_NUMBER          = 12,
    parameter int ITERATION_WORD_INT_WIDTH  = 10,
    parameter int ITERATION_WORD_FRAC_WIDTH = 22
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [UNSIGNED_INPUT_WIDTH-1:0]  x_in,
    input  logic [UNSIGNED_INPUT_WIDTH-1:0]  y_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [UNSIGNED_OUTPUT_WIDTH-1:0] degree_out,
    output logic [UNSIGNED_OUTPUT_WIDTH-1:0] magnitude_out
);
    localparam int FRAC = ITERATION_WORD_FRAC_WIDTH;
    localparam int W    = ITERATION_WORD_INT_WIDTH + FRAC;
    localparam int QF   = 8;
    localparam int OW   = UNSIGNED_OUTPUT_WIDTH;
    localparam logic [3:0] LAST = 4'(ITERATION_NUMBER - 1);
    localparam logic signed [W-1:0] SAT = W'(64'd128 << FRAC);

    typedef logic [15:0][W-1:0] table_t;
    typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

    function automatic real atan_real(input int k);
        case (k)
            0:       return 45.0;
            1:       return 26.565051177077989;
            2:       return 14.036243467926479;
            3:       return 7.125016348901798;
            4:       return 3.576334374997351;
            5:       return 1.789910608246069;
            6:       return 0.895173710211074;
            7:       return 0.447614170860553;
            8:       return 0.223810500368538;
            9:       return 0.111905677066207;
            10:      return 0.055952891893804;
            11:      return 0.027976452617004;
            12:      return 0.013988227142265;
            13:      return 0.006994113675353;
            14:      return 0.003497056850704;
            default: return 0.001748528426980;
        endcase
    endfunction

    // Elaboration-time table, rounded to nearest at the internal fractional width.
    function automatic table_t atan_table();
        table_t t;
        for (int k = 0; k < 16; k++) t[k] = W'($rtoi(atan_real(k) * (2.0 ** FRAC) + 0.5));
        return t;
    endfunction

    localparam table_t ATAN = atan_table();

    function automatic logic [OW-1:0] to_deg(input logic signed [W-1:0] v);
        return v[W-1] ? '0 : OW'(v >>> (FRAC - QF));
    endfunction

    function automatic logic [OW-1:0] to_mag(input logic signed [W-1:0] v);
        return v[W-1] ? '0 : (v >= SAT) ? '1 : OW'(v >>> (FRAC - QF));
    endfunction

    state_t state;
    logic signed [W-1:0] x, y, z, x_n, y_n, z_n;
    logic [3:0] i;
    logic zero;
    logic pos;

    always_comb begin
        pos = ~y[W-1];
        x_n = pos ? x + (y >>> i) : x - (y >>> i);
        y_n = pos ? y - (x >>> i) : y + (x >>> i);
        z_n = pos ? z + $signed(ATAN[i]) : z - $signed(ATAN[i]);
    end

`ifdef VECTOR_GAIN_COMP_EN
    localparam logic signed [W-1:0] KQ = W'($rtoi(0.6072529350 * (2.0 ** FRAC) + 0.5));
    logic signed [W-1:0] scaled;
    assign scaled = W'(((2*W)'(x) * (2*W)'(KQ)) >>> FRAC);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            z             <= '0;
            i             <= '0;
            zero          <= 1'b0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            degree_out    <= '0;
            magnitude_out <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x        <= W'(x_in) << (FRAC - QF);
                    y        <= W'(y_in) << (FRAC - QF);
                    z        <= '0;
                    i        <= '0;
                    zero     <= (x_in == '0) && (y_in == '0);
                    in_ready <= 1'b0;
                    state    <= ITER;
                end
                ITER: begin
                    x <= x_n;
                    y <= y_n;
                    z <= z_n;
                    i <= i + 4'd1;
                    if (i == LAST) begin
`ifdef VECTOR_GAIN_COMP_EN
                        state <= SCALE;
`else
                        state         <= DONE;
                        out_valid     <= 1'b1;
                        degree_out    <= zero ? '0 : to_deg(z_n);
                        magnitude_out <= zero ? '0 : to_mag(x_n);
`endif
                    end
                end
`ifdef VECTOR_GAIN_COMP_EN
                SCALE: begin
                    x             <= scaled;
                    state         <= DONE;
                    out_valid     <= 1'b1;
                    degree_out    <= zero ? '0 : to_deg(z);
                    magnitude_out <= zero ? '0 : to_mag(scaled);
                end
`endif
                default: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
